// File: rtl/hazard_run_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, EX redirects,
// debug halt/single-step, operand forwarding and saturating event counters.
module hazard_run_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_wr,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_wr,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    localparam int              DC_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [DC_W-1:0]  dc_q, dc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             run_like;

    // MEM result is younger than WB, so it wins when both match.
    assign fwd_a = (mem_reg_wr && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) ? 2'b10 :
                   (wb_reg_wr  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs1)) ? 2'b01 : 2'b00;
    assign fwd_b = (mem_reg_wr && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) ? 2'b10 :
                   (wb_reg_wr  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs2)) ? 2'b01 : 2'b00;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    assign run_like = (state_q == S_RUN) || (state_q == S_STEP);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        state_d    = state_q;
        dc_d       = dc_q;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state_q)
                S_RUN, S_STEP: begin
                    if (ex_redirect) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                    // A stalled step keeps the slot open until its instruction issues.
                    if (state_q == S_RUN) begin
                        if (halt_req) begin
                            state_d = S_DRAIN;
                            dc_d    = '0;
                        end
                    end else if (ex_redirect || !load_use) begin
                        state_d = S_DRAIN;
                        dc_d    = '0;
                    end
                end
                S_DRAIN: begin
                    idex_flush = 1'b1;
                    pc_en      = ex_redirect;
                    ifid_flush = ex_redirect;
                    dc_d       = dc_q + 1'b1;
                    if (dc_q == DC_LAST) state_d = S_HALTED;
                end
                default: begin
                    idex_flush = 1'b1;
                    halted     = 1'b1;
                    if (!halt_req)    state_d = S_RUN;
                    else if (step_req) state_d = S_STEP;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (run_like && load_use && !ex_redirect && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_redirect && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            dc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = state_q;

endmodule
